fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the asynchronous program ROM and downstream of nothing but reset and execute-stage redirects. It owns the program counter and drives the ROM address combinationally from it. It registers the returned 21-bit instruction into an instruction register and presents it to the decoder with a valid/ready handshake. It supports stalls, jump redirects and a halt state.

Parameters:
ROM_WIDTH, 21, instruction word width (matches ROM data width)
ADDR_WIDTH, 16, program counter / ROM address width
RESET_PC, 0, address fetched first after reset

Ports:
clk  in  1  single system clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
rom_addr  out  ADDR_WIDTH  ROM address; combinational copy of the PC register
rom_data  in  ROM_WIDTH  ROM instruction word; valid in the same cycle as rom_addr
instr  out  ROM_WIDTH  registered instruction presented to the decoder
instr_pc  out  ADDR_WIDTH  address from which instr was fetched
instr_valid  out  1  instr / instr_pc hold a live instruction
instr_ready  in  1  decoder accepts instr this cycle
redirect  in  1  jump taken; one-cycle pulse from the execute stage
redirect_addr  in  ADDR_WIDTH  jump target, sampled when redirect=1
halt_req  in  1  decoder requests that fetch stop
halted  out  1  fetch is in HALT state

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high; it acts only on the rising edge of `clk`.
- Reset values: pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, halted=0, state=FETCH.
- Reset mid-operation: reset overrides everything, including redirect and halt_req. Any held instruction is discarded.
- rom_addr equals pc at all times, with no register in between. The ROM is combinational, so fetch latency is 1 cycle from PC to instr.
- Load condition: load = (state==FETCH) && (!instr_valid || instr_ready).
- On load:
  - instr <= rom_data, instr_pc <= pc, instr_valid <= 1.
  - pc <= pc+1, modulo 2^ADDR_WIDTH (0xFFFF wraps to 0x0000).
- Consume without load: when instr_valid && instr_ready and no load occurs (HALT state), instr_valid <= 0.
- Stall: when instr_valid && !instr_ready, instr, instr_pc and pc hold their values, and rom_addr stays at the next address.
- First valid instruction appears on the first edge after rst falls: ROM[RESET_PC] is presented at that point.
- Redirect has the highest priority after rst, in any state, and regardless of instr_ready:
  - pc <= redirect_addr, instr_valid <= 0 (the wrong-path instruction is flushed).
  - state <= FETCH, halted <= 0.
  - No load occurs in the redirect cycle. ROM[redirect_addr] is valid one cycle later.
- Halt:
  - halt_req without redirect: state <= HALT and halted <= 1 on the next edge. No further loads occur; pc freezes.
  - A valid instruction already held stays until it is consumed.
  - HALT is exited only by redirect or rst; halt_req deasserting does not resume fetch.
- Simultaneous events:
  - redirect+halt_req: redirect wins and the state stays or becomes FETCH.
  - redirect+instr_ready with valid: the handshake completes (the decoder consumes the word) and the output is still cleared.
- States:
  - FETCH → HALT on halt_req && !redirect.
  - HALT → FETCH on redirect.
  - Either state → FETCH on rst.
- The unit does not decode; all instruction bits pass through unmodified.

Decomposition:
- Package proc_pkg holds ROM_WIDTH, ADDR_WIDTH and RESET_PC defaults.
- proc_pkg also holds the instruction field slices: OPC_MSB=20, OPC_LSB=16, OPERAND_MSB=15, OPERAND_LSB=0.
- proc_pkg also holds the state encoding: FETCH=1'b0, HALT=1'b1.
- One natural sub-module is fetch_pc: the PC register with increment, wrap, hold and load-redirect, plus its enable logic. The top level keeps the IR, the handshake and the FSM.

Test Plan:
- Reset release, ROM[0]=21'h1D0001, ROM[1]=21'h190000, ready=1 → first edge: instr=1D0001, instr_pc=0, valid=1; next edge: instr=190000, instr_pc=1, rom_addr=2.
- Stall: ready=0 for 3 cycles while valid at instr_pc=5 → instr, instr_pc=5 and rom_addr=6 held for all 3 cycles; ready=1 → the next edge loads instr_pc=6.
- Redirect: redirect=1, redirect_addr=0x0004 while valid at instr_pc=0x11 (21'h090003) → next edge valid=0, rom_addr=4; following edge instr=ROM[4], instr_pc=4.
- Wrap: force pc=0xFFFF with ready=1 (ROM default 21'h090008) → instr_pc=0xFFFF, then rom_addr=0x0000, then instr_pc=0.
- Halt and resume: halt_req for 1 cycle → halted=1, pc frozen, the held instr drains on ready; halt_req low 5 cycles, still halted; redirect to 0x0002 → halted=0, instr_pc=2 two edges later.
- Reset mid-stall plus simultaneous redirect/halt_req: rst=1 with valid=1, ready=0 → valid=0, rom_addr=0 next edge; redirect+halt_req together → halted stays 0, fetch continues from redirect_addr.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared widths, instruction field layout and fetch state encoding for the processor front end.
// The instruction word is an opcode field stacked on an address-sized operand field.
package proc_pkg;

  localparam int unsigned OPERAND_LSB = 0;
  localparam int unsigned OPERAND_MSB = 15;
  localparam int unsigned OPC_LSB     = OPERAND_MSB + 1;
  localparam int unsigned OPC_MSB     = 20;

  localparam int unsigned ROM_WIDTH  = OPC_MSB + 1;
  localparam int unsigned ADDR_WIDTH = OPERAND_MSB - OPERAND_LSB + 1;
  localparam int unsigned RESET_PC   = 0;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc.sv
// Program counter for the fetch stage: increments on each instruction load,
// wraps modulo 2^ADDR_WIDTH, holds on stall/halt and jumps on redirect.
module fetch_pc
  import proc_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = proc_pkg::ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  load,
  output logic [ADDR_WIDTH-1:0] pc
);

  // A redirect cycle never loads: the word at the old pc is wrong-path.
  assign load = fetch_en && (!instr_valid || instr_ready) && !redirect;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_addr;
    end else if (load) begin
      pc <= pc + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the asynchronous ROM from the PC, registers the
// returned word into the instruction register and hands it to the decoder via valid/ready.
module fetch_unit
  import proc_pkg::*;
#(
  parameter int unsigned           ROM_WIDTH  = proc_pkg::ROM_WIDTH,
  parameter int unsigned           ADDR_WIDTH = proc_pkg::ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(proc_pkg::RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [ROM_WIDTH-1:0]  rom_data,
  output logic [ROM_WIDTH-1:0]  instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  input  logic                  halt_req,
  output logic                  halted
);

  fetch_state_e          state;
  fetch_state_e          state_next;
  logic                  load;
  logic [ADDR_WIDTH-1:0] pc;

  fetch_pc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_fetch_pc (
    .clk           (clk),
    .rst           (rst),
    .fetch_en      (state == FETCH),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .load          (load),
    .pc            (pc)
  );

  assign rom_addr = pc;
  assign halted   = (state == HALT);

  // NOTE: the default assignment first guarantees state_next is written on
  // every path, so no latch is inferred.
  always_comb begin
    state_next = state;
    if (redirect) begin
      state_next = FETCH;
    end else if (halt_req) begin
      state_next = HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Redirect flushes the output even if the decoder is consuming it this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (redirect) begin
      instr_valid <= 1'b0;
    end else if (load) begin
      instr       <= rom_data;
      instr_pc    <= pc;
      instr_valid <= 1'b1;
    end else if (instr_valid && instr_ready) begin
      instr_valid <= 1'b0;
    end
  end

endmodule
